// File: rtl/ee201_multi_pulse_gen.sv
// ee201_multi_pulse_gen
//   Bank of CH independent programmable pulse generators. Each channel holds a
//   period N, a mode (periodic / one-shot), a run flag and a counter. A running
//   channel with non-zero N emits a one-Clk-wide terminal-count pulse every N
//   cycles. In one-shot mode it emits a single pulse and then stops.
//
// Parameters
//   WIDTH  counter / period width
//   CH     number of channels (1..16)
//   CHW    channel-index width (>= 1)
//
// Ports
//   Clk     system clock, rising edge
//   Reset   asynchronous, active-high reset
//   Ld      load strobe: writes LdN / LdMode into channel LdCh and stops it
//   LdCh    target channel of the load
//   LdN     new period
//   LdMode  0 = periodic, 1 = one-shot
//   Start   per-channel start / phase restart (level-sampled)
//   Stop    per-channel stop (level-sampled)
//   Sync    zero the counter of every running channel
//   Pulse   per-channel terminal-count pulse (combinational from registers)
//   Busy    per-channel run flag
//   LdErr   high for one cycle after a load aimed at a channel >= CH
module ee201_multi_pulse_gen #(
  parameter int WIDTH = 10,
  parameter int CH    = 4,
  parameter int CHW   = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Ld,
  input  logic [CHW-1:0]   LdCh,
  input  logic [WIDTH-1:0] LdN,
  input  logic             LdMode,
  input  logic [CH-1:0]    Start,
  input  logic [CH-1:0]    Stop,
  input  logic             Sync,
  output logic [CH-1:0]    Pulse,
  output logic [CH-1:0]    Busy,
  output logic             LdErr
);

  logic [WIDTH-1:0] nreg_q  [CH];
  logic [WIDTH-1:0] nreg_d  [CH];
  logic [WIDTH-1:0] count_q [CH];
  logic [WIDTH-1:0] count_d [CH];
  logic [CH-1:0]    mode_q, mode_d;
  logic [CH-1:0]    run_q, run_d;
  logic             lderr_q, lderr_d;
  logic             ld_valid;
  logic [CH-1:0]    tc;

  // A load whose index is out of range touches no channel and only flags LdErr.
  assign ld_valid = Ld && (32'(LdCh) < CH);

  // Terminal count: last cycle of the period on a running, non-zero channel.
  always_comb begin
    tc = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      tc[i] = run_q[i] && (nreg_q[i] != '0) &&
              (count_q[i] == nreg_q[i] - WIDTH'(1));
    end
  end

  // Per-channel priority: load > Stop > Start > Sync > normal count.
  always_comb begin
    lderr_d = Ld && !ld_valid;
    for (int unsigned i = 0; i < CH; i++) begin
      nreg_d[i]  = nreg_q[i];
      mode_d[i]  = mode_q[i];
      run_d[i]   = run_q[i];
      count_d[i] = count_q[i];
      if (ld_valid && (LdCh == CHW'(i))) begin
        nreg_d[i]  = LdN;
        mode_d[i]  = LdMode;
        run_d[i]   = 1'b0;
        count_d[i] = '0;
      end else if (Stop[i]) begin
        run_d[i]   = 1'b0;
        count_d[i] = '0;
      end else if (Start[i]) begin
        run_d[i]   = 1'b1;
        count_d[i] = '0;
      end else if (run_q[i]) begin
        if (Sync) begin
          count_d[i] = '0;
        end else if (nreg_q[i] != '0) begin
          if (tc[i]) begin
            count_d[i] = '0;
            if (mode_q[i]) run_d[i] = 1'b0;
          end else begin
            count_d[i] = count_q[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < CH; i++) begin
        nreg_q[i]  <= '0;
        count_q[i] <= '0;
      end
      mode_q  <= '0;
      run_q   <= '0;
      lderr_q <= 1'b0;
    end else begin
      nreg_q  <= nreg_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      lderr_q <= lderr_d;
    end
  end

  assign Pulse = tc;
  assign Busy  = run_q;
  assign LdErr = lderr_q;

endmodule
